spi_tx_shift_register: RTL
==========================

Name: spi_tx_shift_register

Overview:
SPI transmit-side shifter, the counterpart of the team's SPI receive shift register. It accepts parallel bytes through a valid/ready handshake into a one-entry holding buffer. Each byte is serialized onto data_out, one bit per spi_clk, while load_out is driven high as the frame qualifier. Back-to-back bytes stream with no idle gap, so data_out/load_out connect directly to the receiver's data_in/load.

Parameters:
DATA_WIDTH, 8, bits per frame; must be >= 2.
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first.

Ports:
spi_clk  input  1  sole clock; all state updates on the rising edge.
reset  input  1  synchronous reset, active-low; sampled on the rising edge of spi_clk.
tx_data  input  DATA_WIDTH  parallel byte to send; sampled only in an accepting cycle.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  holding buffer empty. tx_ready = reset & ~hold_full.
data_out  output  1  serial data bit (registered).
load_out  output  1  high while data_out carries a valid frame bit (registered).
busy  output  1  state == SHIFT, or hold_full.
tx_done  output  1  one-cycle pulse at the end of each frame (registered).

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, hold_full=0, bit_cnt=0, shift register=0.
  - data_out=0, load_out=0, tx_done=0; tx_ready=0 while reset is low.
  - Reset mid-frame aborts immediately. Any partial frame and held byte are discarded, with no tx_done.
- Accept: at an edge with tx_valid & tx_ready, capture tx_data into hold and set hold_full=1.
  - tx_valid while tx_ready=0 is ignored; nothing is captured or lost inside the block.
  - The source must hold tx_valid/tx_data until accepted.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - data_out=0, load_out=0.
  - If hold_full at an edge:
    - move hold to the shift register; clear hold_full;
    - bit_cnt=DATA_WIDTH-1; state=SHIFT;
    - drive the first bit on data_out; load_out=1.
- SHIFT, each edge:
  - If bit_cnt != 0: shift by one, present the next bit, decrement bit_cnt; load_out stays 1.
  - If bit_cnt == 0 (last bit just completed), tx_done=1 for this next cycle only, and:
    - if hold_full: reload directly from hold (same rules as IDLE entry). State stays SHIFT and load_out stays 1, so there is zero gap.
    - else: state=IDLE, load_out=0, data_out=0.
- Bit order:
  - MSB_FIRST=1: bit DATA_WIDTH-1 is sent first; shift left; data_out = shreg[DATA_WIDTH-1].
  - MSB_FIRST=0: bit 0 is sent first; shift right; data_out = shreg[0].
- Latency:
  - Byte accepted at edge N.
  - First bit valid from edge N+1.
  - load_out high for exactly DATA_WIDTH cycles per frame.
  - tx_done high in the cycle after the last bit.
- Simultaneous events:
  - The hold-to-shift transfer and a new accept can never occur on the same edge, because tx_ready is low whenever hold_full=1.
  - An accept on the same edge as a frame's last bit is legal. It lands in hold; that byte starts at the next frame boundary, not this edge.
- Throughput: sustained one byte per DATA_WIDTH cycles once hold is refilled during each frame.
- tx_done and load_out may both be 1 in the first cycle of a back-to-back frame.

Test Plan:
- Single byte: reset low for 5 edges, then tx_data=0x96 with tx_valid for 1 cycle. Required response:
  - data_out = 1,0,0,1,0,1,1,0 on 8 consecutive cycles starting 1 edge after accept, with load_out=1 throughout;
  - then load_out=0, data_out=0, and tx_done=1 for exactly 1 cycle.
- Back-to-back: send 0xA5 then 0x3C, the second presented while the first is shifting. Required response:
  - load_out stays high for 16 consecutive cycles, data_out = 10100101 00111100;
  - two tx_done pulses, 8 cycles apart.
- Backpressure: hold tx_valid high with 3 bytes (0x11, 0x22, 0x33). Required response:
  - tx_ready drops after each accept and no byte is dropped or duplicated;
  - 24 contiguous frame bits are sent in order.
- Reset mid-frame: assert reset after the 3rd bit of 0xFF with 0x0F held. Required response:
  - next edge: load_out=0, data_out=0, busy=0, no tx_done;
  - after release, tx_ready=1 and nothing is transmitted until a new accept.
- MSB_FIRST=0, DATA_WIDTH=8, send 0x01 → data_out = 1,0,0,0,0,0,0,0.
- Loopback into the SPI receive shift register (data_out to data_in, load_out to load), send 0x69 → receiver data_out reads 0x69 after the frame completes.

Source files
------------

// File: rtl/spi_tx_shift_register.sv
// spi_tx_shift_register
//   SPI transmit-side shifter. Parallel words enter through a valid/ready
//   handshake into a one-entry holding buffer and are serialized onto
//   data_out, one bit per spi_clk, with load_out high as the frame qualifier.
//   A word waiting in the holding buffer is reloaded at the frame boundary,
//   so consecutive frames stream with no idle cycle between them.
//
// Ports
//   spi_clk   in   sole clock, rising edge
//   reset     in   synchronous reset, active low
//   tx_data   in   [DATA_WIDTH-1:0] parallel word, sampled when accepted
//   tx_valid  in   tx_data is valid
//   tx_ready  out  holding buffer empty and not in reset
//   data_out  out  serial data bit (registered)
//   load_out  out  high while data_out carries a frame bit (registered)
//   busy      out  shifting a frame or holding a word
//   tx_done   out  one-cycle pulse in the cycle after a frame's last bit
module spi_tx_shift_register #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  spi_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  data_out,
    output logic                  load_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_full_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] shreg_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [CNT_W-1:0]      bit_cnt_s;
    logic                  data_out_r;
    logic                  data_out_s;
    logic                  load_out_r;
    logic                  load_out_s;
    logic                  tx_done_r;
    logic                  tx_done_s;
    logic                  xfer_s;
    logic                  accept_s;
    logic                  tx_ready_s;

    // Bit that goes on the wire first for a freshly loaded word.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[DATA_WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [DATA_WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[DATA_WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[DATA_WIDTH-1:1]};
        end
    endfunction

    assign tx_ready_s = reset & ~hold_full_r;
    assign accept_s   = tx_valid & tx_ready_s;
    assign shifted_s  = shift_one(shreg_r);

    // Next-state and next-output logic; xfer_s moves hold into the shifter.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        bit_cnt_s  = bit_cnt_r;
        data_out_s = 1'b0;
        load_out_s = 1'b0;
        tx_done_s  = 1'b0;
        xfer_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    xfer_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r != {CNT_W{1'b0}}) begin
                    shreg_s    = shifted_s;
                    data_out_s = first_bit(shifted_s);
                    bit_cnt_s  = bit_cnt_r - CNT_W'(1);
                    load_out_s = 1'b1;
                end else begin
                    // Last bit has just been on the wire for a full cycle.
                    tx_done_s = 1'b1;
                    if (hold_full_r) begin
                        xfer_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (xfer_s) begin
            shreg_s    = hold_r;
            bit_cnt_s  = CNT_LAST;
            state_s    = ST_SHIFT;
            data_out_s = first_bit(hold_r);
            load_out_s = 1'b1;
        end else begin
            shreg_s = shreg_s;
        end
    end

    // State, shifter and registered outputs.
    always_ff @(posedge spi_clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            data_out_r <= 1'b0;
            load_out_r <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bit_cnt_r  <= bit_cnt_s;
            data_out_r <= data_out_s;
            load_out_r <= load_out_s;
            tx_done_r  <= tx_done_s;
        end
    end

    // Holding buffer; a transfer and an accept never coincide since
    // tx_ready is low whenever the buffer is full.
    always_ff @(posedge spi_clk) begin
        if (!reset) begin
            hold_r      <= {DATA_WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else if (xfer_s) begin
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= tx_data;
            hold_full_r <= 1'b1;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    assign tx_ready = tx_ready_s;
    assign data_out = data_out_r;
    assign load_out = load_out_r;
    assign busy     = (state_r == ST_SHIFT) | hold_full_r;
    assign tx_done  = tx_done_r;

endmodule
